abp_receiver_frame_checker: RTL

ABP_RECEIVER_FRAME_CHECKER -- requirements
Module: abp_receiver_frame_checker

---
 rtl/abp_receiver_frame_checker_if.sv | 12 +
 rtl/abp_receiver_frame_checker.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/abp_receiver_frame_checker_if.sv
// Byte-stream handshake bundle shared by the link side and the user side of the ABP receiver.
interface abp_receiver_frame_checker_if #(
  parameter int DATA_W = 8
);
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [DATA_W-1:0] tdata;

  modport master (output tvalid, output tlast, output tdata, input tready);
  modport slave  (input tvalid, input tlast, input tdata, output tready);
endinterface

// File: rtl/abp_receiver_frame_checker.sv
// Alternating-bit receiver: buffers one frame, drops malformed/duplicate frames and
// streams the payload of each new frame to the user before accepting the next one.
module abp_receiver_frame_checker #(
  parameter int FRAME_BYTES = 64
) (
  input  logic                                aclk,
  input  logic                                aresetn,
  abp_receiver_frame_checker_if.slave         s_axis,
  abp_receiver_frame_checker_if.master        m_axis,
  output logic                                alternating_bit,
  output logic                                busy,
  output logic                                dup_pulse,
  output logic                                err_pulse
);

  localparam int IDX_W = $clog2(FRAME_BYTES) + 1;
  localparam int AW    = (FRAME_BYTES > 2) ? $clog2(FRAME_BYTES - 1) : 1;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    RX_HEADER  = 2'd0,
    RX_PAYLOAD = 2'd1,
    DRAIN      = 2'd2,
    TX_PAYLOAD = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic              seq;
  logic              hdr_err;
  logic [IDX_W-1:0]  idx;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [7:0]        buf_mem [0:DEPTH-1];
  logic              m_vld;
  logic              m_last;
  logic [7:0]        m_data;

  logic s_hs, m_hs, at_last;
  logic err_set, dup_set, hdr_take, tx_start;
  logic [7:0] first_byte;

  assign s_axis.tready = (state != TX_PAYLOAD);
  assign m_axis.tvalid = m_vld;
  assign m_axis.tlast  = m_last;
  assign m_axis.tdata  = m_data;
  assign busy          = (state == TX_PAYLOAD);

  assign s_hs    = s_axis.tvalid & s_axis.tready;
  assign m_hs    = m_vld & m_axis.tready;
  assign at_last = (idx == IDX_W'(FRAME_BYTES - 1));
  // With a single payload byte it is still being written when delivery starts.
  assign first_byte = (idx == IDX_W'(1)) ? s_axis.tdata : buf_mem[0];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= RX_HEADER;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    err_set   = 1'b0;
    dup_set   = 1'b0;
    hdr_take  = 1'b0;
    tx_start  = 1'b0;
    case (state)
      RX_HEADER: begin
        if (s_hs) begin
          if (s_axis.tlast) begin
            err_set = 1'b1;
          end else begin
            hdr_take  = 1'b1;
            state_nxt = RX_PAYLOAD;
          end
        end
      end
      RX_PAYLOAD: begin
        if (s_hs) begin
          if (s_axis.tlast) begin
            state_nxt = RX_HEADER;
            if (!at_last || hdr_err) begin
              err_set = 1'b1;
            end else if (seq == alternating_bit) begin
              dup_set = 1'b1;
            end else begin
              tx_start  = 1'b1;
              state_nxt = TX_PAYLOAD;
            end
          end else if (at_last) begin
            err_set   = 1'b1;
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (s_hs && s_axis.tlast) state_nxt = RX_HEADER;
      end
      TX_PAYLOAD: begin
        if (m_hs && m_last) state_nxt = RX_HEADER;
      end
      default: state_nxt = RX_HEADER;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      seq             <= 1'b0;
      hdr_err         <= 1'b0;
      idx             <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      alternating_bit <= 1'b1;
      m_vld           <= 1'b0;
      m_last          <= 1'b0;
      m_data          <= '0;
      dup_pulse       <= 1'b0;
      err_pulse       <= 1'b0;
    end else begin
      dup_pulse <= dup_set;
      err_pulse <= err_set;

      if (hdr_take) begin
        seq     <= s_axis.tdata[0];
        hdr_err <= |s_axis.tdata[7:1];
        idx     <= IDX_W'(1);
        wr_ptr  <= '0;
      end else if (state == RX_PAYLOAD && s_hs) begin
        idx    <= idx + IDX_W'(1);
        wr_ptr <= wr_ptr + AW'(1);
      end

      // Output register: loaded at frame completion, then advanced one byte per handshake.
      if (tx_start) begin
        m_vld  <= 1'b1;
        m_data <= first_byte;
        m_last <= (FRAME_BYTES == 2);
        rd_ptr <= AW'(1);
      end else if (m_hs) begin
        if (m_last) begin
          m_vld           <= 1'b0;
          m_last          <= 1'b0;
          alternating_bit <= seq;
        end else begin
          m_data <= buf_mem[rd_ptr];
          m_last <= (rd_ptr == AW'(FRAME_BYTES - 2));
          rd_ptr <= rd_ptr + AW'(1);
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (state == RX_PAYLOAD && s_hs) buf_mem[wr_ptr] <= s_axis.tdata;
  end

endmodule
